// File: rtl/clock_enable_scheduler.sv
// clock_enable_scheduler: runtime-programmable tick/clock-enable generator.
// A divisor D arrives over a valid/ready handshake. Every D cycles the block
// emits a one-cycle tick, and it drives a registered square wave of period D.
// Divisor changes and stop requests only take effect at period boundaries.
module clock_enable_scheduler #(
  parameter int WIDTH            = 16,
  parameter int DEFAULT_DIVISION = 4
) (
  input  logic             masterClock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] divisorIn,
  input  logic             divisorValid,
  output logic             divisorReady,
  output logic             divisorError,
  output logic [WIDTH-1:0] activeDivisor,
  output logic             tickEnable,
  output logic             dividedClock,
  output logic             running
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_full_q, pending_full_d;
  logic             error_q, error_d;
  logic             divided_q, divided_d;

  logic is_running;
  logic at_boundary;
  logic transfer;
  logic accept_ok;

  assign is_running  = (state_q != IDLE);
  assign at_boundary = is_running && (count_q == (active_q - 1'b1));
  assign transfer    = divisorValid && !pending_full_q;
  assign accept_ok   = transfer && (divisorIn >= WIDTH'(2));

  // Next-state logic: sequencing, period counter, divisor slot and wave output
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    error_d        = transfer && !accept_ok;

    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = STOPPING;
      end
      STOPPING: begin
        if (enable)           state_d = RUN;
        else if (at_boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!is_running) begin
      // While idle there is no period in flight, so a divisor lands directly.
      count_d = '0;
      if (accept_ok) active_d = divisorIn;
    end else begin
      count_d = at_boundary ? '0 : count_q + 1'b1;
      if (at_boundary && pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end
      if (accept_ok) begin
        // On the edge that parks the block in IDLE there is no later boundary
        // to drain the slot, so the divisor is applied straight away.
        if (state_d == IDLE) begin
          active_d = divisorIn;
        end else begin
          pending_d      = divisorIn;
          pending_full_d = 1'b1;
        end
      end
    end

    divided_d = (state_d != IDLE) && (count_d < (active_d >> 1));
  end

  // State registers with synchronous reset that aborts any period in flight
  always_ff @(posedge masterClock) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      active_q       <= WIDTH'(DEFAULT_DIVISION);
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      error_q        <= 1'b0;
      divided_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      error_q        <= error_d;
      divided_q      <= divided_d;
    end
  end

  assign divisorReady  = !pending_full_q;
  assign divisorError  = error_q;
  assign activeDivisor = active_q;
  assign tickEnable    = at_boundary;
  assign dividedClock  = divided_q;
  assign running       = is_running;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// tb_clock_enable_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_clock_enable_scheduler;

  localparam int WIDTH = 16;
  localparam int DEF   = 4;

  logic             masterClock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] divisorIn = '0;
  logic             divisorValid = 1'b0;
  logic             divisorReady;
  logic             divisorError;
  logic [WIDTH-1:0] activeDivisor;
  logic             tickEnable;
  logic             dividedClock;
  logic             running;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "on" means counting, "stopReq" means the current
  // period is the last one unless enable returns.
  bit m_on;
  bit m_stop_req;
  int m_count;
  int m_div;
  int m_pend[$];
  bit m_err;

  clock_enable_scheduler #(.WIDTH(WIDTH), .DEFAULT_DIVISION(DEF)) dut (
    .masterClock  (masterClock),
    .reset        (reset),
    .enable       (enable),
    .divisorIn    (divisorIn),
    .divisorValid (divisorValid),
    .divisorReady (divisorReady),
    .divisorError (divisorError),
    .activeDivisor(activeDivisor),
    .tickEnable   (tickEnable),
    .dividedClock (dividedClock),
    .running      (running)
  );

  // 125 MHz master clock
  always #4 masterClock = ~masterClock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs sampled there.
  task automatic modelEdge(input bit rst, input bit en, input bit vld, input int din);
    bit xfer;
    bit last;
    if (rst) begin
      m_on = 0; m_stop_req = 0; m_count = 0; m_div = DEF; m_pend.delete(); m_err = 0;
      return;
    end
    xfer  = vld && (m_pend.size() == 0);
    m_err = xfer && (din < 2);
    if (!m_on) begin
      if (xfer && din >= 2) m_div = din;
      m_count = 0;
      if (en) begin m_on = 1; m_stop_req = 0; end
      return;
    end
    last = (m_count == m_div - 1);
    if (last) begin
      m_count = 0;
      if (m_pend.size() != 0) m_div = m_pend.pop_front();
    end else begin
      m_count++;
    end
    if (en) begin
      m_stop_req = 0;
    end else if (m_stop_req && last) begin
      m_on = 0; m_stop_req = 0; m_count = 0;
    end else begin
      m_stop_req = 1;
    end
    if (xfer && din >= 2) begin
      if (!m_on) m_div = din;
      else m_pend.push_back(din);
    end
  endtask

  // One cycle: drive inputs, let the edge pass, then compare all outputs.
  task automatic applyStimulus(input bit rst, input bit en, input bit vld, input int din);
    reset = rst; enable = en; divisorValid = vld; divisorIn = WIDTH'(din);
    @(posedge masterClock);
    modelEdge(rst, en, vld, din);
    @(negedge masterClock);
    checkOutput("running", 32'(running), 32'(m_on));
    checkOutput("divisorReady", 32'(divisorReady), 32'(m_pend.size() == 0));
    checkOutput("divisorError", 32'(divisorError), 32'(m_err));
    checkOutput("activeDivisor", 32'(activeDivisor), 32'(m_div));
    checkOutput("tickEnable", 32'(tickEnable), 32'(m_on && m_count == m_div - 1));
    checkOutput("dividedClock", 32'(dividedClock), 32'(m_on && m_count < m_div / 2));
  endtask

  initial begin
    bit en_r;
    bit vld_r;
    int din_r;

    // Reset and the default divisor of 4
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("resetActiveDivisor", 32'(activeDivisor), 32'(DEF));
    checkOutput("resetReady", 32'(divisorReady), 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0);

    // Mid-period change to 6 (written while count is 1)
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 6);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0);

    // Rejected divisors 1 and 0
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);

    // Back to 4, then stop mid-period (case A)
    applyStimulus(0, 1, 1, 4);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    // Stop then re-raise enable before the boundary (case B)
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);

    // D=5, then a pending divisor, then reset mid-period
    applyStimulus(0, 1, 1, 5);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 7);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("midResetDivisor", 32'(activeDivisor), 32'(DEF));
    checkOutput("midResetRunning", 32'(running), 32'd0);

    // In IDLE: divisor 3 and enable on the same edge
    applyStimulus(0, 1, 1, 3);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    // Random traffic; a stalled request keeps its divisor until accepted
    en_r = 1; vld_r = 0; din_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(vld_r && m_pend.size() != 0)) begin
        vld_r = ($urandom_range(0, 9) < 3);
        din_r = $urandom_range(0, 9);
      end
      if ($urandom_range(0, 19) == 0) en_r = !en_r;
      if ($urandom_range(0, 199) == 0) begin
        applyStimulus(1, en_r, vld_r, din_r);
        vld_r = 0;
      end else begin
        applyStimulus(0, en_r, vld_r, din_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Runtime-programmable clock-enable generator for the Zybo 125 MHz master clock domain; replaces fixed compile-time division with a divisor loaded by valid/ready handshake.
- Produces a one-cycle tick enable per period plus a registered square wave.
- Divisor changes and stop requests take effect only at period boundaries, so there are no runt periods or truncated pulses.
- Sits between control logic (register bank / FSMs) and downstream logic that consumes tick enables.

Parameters:
- WIDTH, 16, width of divisor and internal period counter.
- DEFAULT_DIVISION, 4, active divisor after reset; must be in 2..2^WIDTH-1.

Ports:
- masterClock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; request to run (1) or stop (0).
- divisorIn  input  WIDTH  requested divisor D.
- divisorValid  input  1  divisorIn is valid.
- divisorReady  output  1  block can accept a divisor this cycle.
- divisorError  output  1  one-cycle pulse when an accepted divisor was rejected (D<2).
- activeDivisor  output  WIDTH  divisor currently governing the count.
- tickEnable  output  1  one-cycle pulse in the last cycle of each period.
- dividedClock  output  1  registered square wave, period D cycles.
- running  output  1  high in RUN and STOPPING.

Behaviour:
- Reset: state=IDLE, count=0, activeDivisor=DEFAULT_DIVISION, pending slot empty. Outputs: divisorReady=1, divisorError=0, tickEnable=0, dividedClock=0, running=0. Reset asserted mid-operation aborts the current period; all outputs hold these values on the cycle after the reset edge.
- Counter: count runs 0..D-1, where D=activeDivisor, and wraps to 0. In RUN/STOPPING, tickEnable=1 exactly when count==D-1.
- dividedClock is a flop. In any RUN/STOPPING cycle its value equals (count < D>>1): high for floor(D/2) cycles, low for the remainder. It is 0 in IDLE.
- Handshake: a transfer occurs when divisorValid && divisorReady on a rising edge. divisorReady = pending slot empty (one-entry buffer). The requester holds divisorIn stable while valid && !ready.
- Rejection: an accepted D<2 is discarded. divisorError pulses on the next cycle; activeDivisor and the pending slot are unchanged.
- IDLE:
  - count=0 and outputs are low.
  - An accepted divisor writes activeDivisor directly on that edge; the pending slot is not used.
  - enable=1 goes to RUN. The first RUN cycle has count=0.
  - If a divisor is accepted in the same cycle that enable rises, the first period uses the new D.
- RUN:
  - An accepted divisor goes into the pending slot, and divisorReady drops.
  - On the edge where count==D-1: activeDivisor takes the pending value, the slot empties, divisorReady returns to 1, and count=0. The new period runs with the new D.
  - enable=0 goes to STOPPING; the current period continues.
- STOPPING:
  - Counting and ticks continue.
  - On the edge with count==D-1: go to IDLE, count=0, and apply any pending divisor.
  - enable=1 while in STOPPING returns to RUN with no break in counting.
  - The final tick of the period is always emitted.
- Simultaneous events:
  - Boundary apply and a new transfer in the same cycle cannot occur, because ready is low while the slot is full.
  - Reset dominates all other inputs.
- No combinational path from any input to any output; all outputs are registered or decoded only from registers.

Test Plan:
- Reset, then enable=1 with default D=4 -> tickEnable high at RUN cycles 3, 7, 11; dividedClock pattern 1,1,0,0 repeating; running=1.
- During RUN with D=4 at count=1, write D=6 -> divisorReady=0 until the count==3 edge. activeDivisor=6 from the next cycle; next ticks 6 cycles apart; dividedClock high 3, low 3.
- Write D=1 (also D=0) -> divisorError pulses once; activeDivisor unchanged; divisorReady stays 1; period unaffected.
- Case A: D=4, drop enable at count=1 -> tick still fires at count=3, then IDLE with all outputs 0. Case B: as A, but re-raise enable at count=2 -> no gap in ticks, state back to RUN.
- Assert reset at count=2 of D=5 with a divisor pending -> next cycle: count=0, IDLE, activeDivisor=4, divisorReady=1, tickEnable=0, dividedClock=0.
- In IDLE, raise divisorValid with D=3 and enable=1 on the same edge -> first tick at RUN cycle 2; dividedClock pattern 1,0,0.
